// File: rtl/flag_cond_unit_pkg.sv
// Shared flag bit positions and condition-code encodings for the flag/condition unit.
package flag_cond_unit_pkg;

  localparam int FLAG_W = 5;
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [3:0] {
    CC_EQ  = 4'd0,
    CC_NE  = 4'd1,
    CC_GE  = 4'd2,
    CC_CS  = 4'd3,
    CC_CC  = 4'd4,
    CC_HI  = 4'd5,
    CC_LS  = 4'd6,
    CC_LO  = 4'd7,
    CC_HS  = 4'd8,
    CC_GRT = 4'd9,
    CC_LE  = 4'd10,
    CC_FS  = 4'd11,
    CC_FC  = 4'd12,
    CC_LT  = 4'd13,
    CC_UC  = 4'd14,
    CC_AT  = 4'd15
  } cond_code_e;

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational predicate: one 4-bit condition code against the five flags.
module flag_cond_eval
  import flag_cond_unit_pkg::*;
(
  input  logic [3:0]        code_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              met_o
);

  logic c, l, f, n, z;

  always_comb begin
    c = flags_i[FLAG_C];
    l = flags_i[FLAG_L];
    f = flags_i[FLAG_F];
    n = flags_i[FLAG_N];
    z = flags_i[FLAG_Z];
    met_o = 1'b0;
    case (code_i)
      CC_EQ:   met_o = z;
      CC_NE:   met_o = ~z;
      CC_GE:   met_o = n | z;
      CC_CS:   met_o = c;
      CC_CC:   met_o = ~c;
      CC_HI:   met_o = l;
      CC_LS:   met_o = ~l;
      CC_LO:   met_o = ~(l & z);
      CC_HS:   met_o = ~(l | z);
      CC_GRT:  met_o = n;
      CC_LE:   met_o = ~n;
      CC_FS:   met_o = f;
      CC_FC:   met_o = ~f;
      CC_LT:   met_o = ~(n & z);
      CC_UC:   met_o = 1'b0;
      CC_AT:   met_o = 1'b1;
      default: met_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flag register with a LIFO save stack for interrupt entry/exit and
// NUM_CH independent registered condition evaluators fed by forwarded next-flags.
module flag_cond_unit
  import flag_cond_unit_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLAG_W-1:0]     flag_we,
  input  logic [FLAG_W-1:0]     flag_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic [4*NUM_CH-1:0]   cond_code,
  input  logic [NUM_CH-1:0]     cond_valid,
  output logic [NUM_CH-1:0]     code_met,
  output logic [NUM_CH-1:0]     met_valid,
  output logic [FLAG_W-1:0]     flags,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_err
);

  localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW   = IDXW + 1;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] met_q, met_d, vld_q, met_w;
  logic              push_do, pop_do, bad_op;
  logic [IDXW-1:0]   top_idx, wr_idx;

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CW'(STACK_DEPTH));

  // Simultaneous push and pop cancel out: no stack motion and no error.
  assign push_do = push & ~pop & ~stack_full;
  assign pop_do  = pop & ~push & ~stack_empty;
  assign bad_op  = (push & ~pop & stack_full) | (pop & ~push & stack_empty);

  assign top_idx = IDXW'(count_q - CW'(1));
  assign wr_idx  = IDXW'(count_q);

  always_comb begin
    flags_d = pop_do ? stack_q[top_idx] : ((flag_we & flag_in) | (~flag_we & flags_q));
    count_d = count_q;
    if (push_do)
      count_d = count_q + CW'(1);
    else if (pop_do)
      count_d = count_q - CW'(1);
    err_d = err_q | bad_op;
  end

  // Evaluators see flags_d so a request sees the update landing on the same edge.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    flag_cond_eval u_eval (
      .code_i  (cond_code[4*i +: 4]),
      .flags_i (flags_d),
      .met_o   (met_w[i])
    );
  end

  assign met_d = met_w & cond_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      met_q   <= '0;
      vld_q   <= '0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
      met_q   <= met_d;
      vld_q   <= cond_valid;
    end
  end

  // Stack storage is left uninitialised; count alone defines what is live.
  always_ff @(posedge clk) begin
    if (push_do)
      stack_q[wr_idx] <= flags_q;
  end

  assign flags     = flags_q;
  assign stack_err = err_q;
  assign code_met  = met_q;
  assign met_valid = vld_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Scoreboarded bench for flag_cond_unit: directed vectors queue expected results per channel,
// a negedge monitor pops and compares; flag/stack status is checked after each edge.
module tb_flag_cond_unit;
  import flag_cond_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] flag_we, flag_in;
  logic       push, pop;
  logic [7:0] cond_code;
  logic [1:0] cond_valid;
  logic [1:0] code_met, met_valid;
  logic [4:0] flags;
  logic       stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;
  bit q0[$];
  bit q1[$];

  flag_cond_unit #(.NUM_CH(2), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flag_we    (flag_we),
    .flag_in    (flag_in),
    .push       (push),
    .pop        (pop),
    .cond_code  (cond_code),
    .cond_valid (cond_valid),
    .code_met   (code_met),
    .met_valid  (met_valid),
    .flags      (flags),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented result.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (met_valid[0] === 1'b1) begin
        if (q0.size() == 0) chk("ch0_unexpected_valid", 32'd1, 32'd0);
        else chk("ch0_code_met", {31'd0, code_met[0]}, {31'd0, q0.pop_front()});
      end else chk("ch0_idle_zero", {31'd0, code_met[0]}, 32'd0);
      if (met_valid[1] === 1'b1) begin
        if (q1.size() == 0) chk("ch1_unexpected_valid", 32'd1, 32'd0);
        else chk("ch1_code_met", {31'd0, code_met[1]}, {31'd0, q1.pop_front()});
      end else chk("ch1_idle_zero", {31'd0, code_met[1]}, 32'd0);
    end
  end

  task automatic drv(input logic [4:0] we, input logic [4:0] fin, input logic ps, input logic pp,
                     input logic [3:0] c0, input logic [3:0] c1, input logic [1:0] v,
                     input bit e0, input bit e1);
    flag_we    = we;
    flag_in    = fin;
    push       = ps;
    pop        = pp;
    cond_code  = {c1, c0};
    cond_valid = v;
    if (v[0]) q0.push_back(e0);
    if (v[1]) q1.push_back(e1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flag_we = '0; flag_in = '0; push = 1'b0; pop = 1'b0;
    cond_code = '0; cond_valid = '0;
    #12;
    chk("rst_flags", {27'd0, flags}, 32'd0);
    chk("rst_empty", {31'd0, stack_empty}, 32'd1);
    chk("rst_full", {31'd0, stack_full}, 32'd0);
    chk("rst_err", {31'd0, stack_err}, 32'd0);
    chk("rst_met_valid", {30'd0, met_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Forwarding and predicate coverage; flags {C,L,F,N,Z}
    drv(5'b00001, 5'b00001, 0, 0, CC_EQ, CC_UC, 2'b01, 1, 0);
    chk("fwd_flags", {27'd0, flags}, 32'h01);
    drv(5'b11111, 5'b10000, 0, 0, CC_CS, CC_HI, 2'b11, 1, 0);
    drv(5'b00000, 5'b00000, 0, 0, CC_CS, CC_AT, 2'b01, 1, 0);
    chk("ch1_novalid_vld", {31'd0, met_valid[1]}, 32'd0);
    chk("ch1_novalid_met", {31'd0, code_met[1]}, 32'd0);
    drv(5'b11111, 5'b01010, 0, 0, CC_LO, CC_GE, 2'b11, 1, 1);
    drv(5'b00000, 5'b00000, 0, 0, CC_HS, CC_LT, 2'b11, 0, 1);
    drv(5'b00000, 5'b00000, 0, 0, CC_UC, CC_AT, 2'b11, 0, 1);
    drv(5'b00000, 5'b00000, 0, 0, CC_FS, CC_FC, 2'b11, 0, 1);
    drv(5'b00000, 5'b00000, 0, 0, CC_NE, CC_LS, 2'b11, 1, 0);
    drv(5'b00000, 5'b00000, 0, 0, CC_LE, CC_GRT, 2'b11, 0, 1);
    drv(5'b00000, 5'b00000, 0, 0, CC_CC, CC_EQ, 2'b11, 1, 0);
    drv(5'b00100, 5'b11111, 0, 0, CC_FS, CC_HI, 2'b11, 1, 1);
    chk("partial_we_flags", {27'd0, flags}, 32'h0E);
    drv(5'b10001, 5'b10001, 0, 0, CC_LT, CC_HS, 2'b11, 0, 0);
    chk("partial_we_flags2", {27'd0, flags}, 32'h1F);

    // Push/pop interplay at count 2, then pop on empty
    drv(5'b11111, 5'b00110, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    chk("push_we_flags", {27'd0, flags}, 32'h06);
    chk("push_not_empty", {31'd0, stack_empty}, 32'd0);
    drv(5'b00000, 5'b00000, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    drv(5'b11111, 5'b01001, 1, 1, CC_UC, CC_UC, 2'b00, 0, 0);
    chk("pushpop_err", {31'd0, stack_err}, 32'd0);
    chk("pushpop_flags", {27'd0, flags}, 32'h09);
    chk("pushpop_full", {31'd0, stack_full}, 32'd0);
    drv(5'b00000, 5'b00000, 0, 1, CC_EQ, CC_UC, 2'b01, 0, 0);
    chk("pop1_flags", {27'd0, flags}, 32'h06);
    drv(5'b11111, 5'b00000, 0, 1, CC_UC, CC_FS, 2'b10, 0, 1);
    chk("pop2_flags", {27'd0, flags}, 32'h1F);
    chk("pop2_empty", {31'd0, stack_empty}, 32'd1);
    chk("pop2_err", {31'd0, stack_err}, 32'd0);
    drv(5'b11111, 5'b00101, 0, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    drv(5'b10000, 5'b10000, 0, 1, CC_CS, CC_UC, 2'b01, 1, 0);
    chk("underflow_err", {31'd0, stack_err}, 32'd1);
    chk("underflow_flags", {27'd0, flags}, 32'h15);
    chk("underflow_empty", {31'd0, stack_empty}, 32'd1);

    // Asynchronous reset mid-cycle with count 3, error set, request in flight
    drv(5'b00000, 5'b00000, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    drv(5'b00000, 5'b00000, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    drv(5'b00000, 5'b00000, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    chk("cnt3_full", {31'd0, stack_full}, 32'd0);
    chk("cnt3_err", {31'd0, stack_err}, 32'd1);
    push = 1'b0;
    cond_code = {CC_AT, CC_AT};
    cond_valid = 2'b11;
    #3;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("async_rst_flags", {27'd0, flags}, 32'd0);
    chk("async_rst_empty", {31'd0, stack_empty}, 32'd1);
    chk("async_rst_err", {31'd0, stack_err}, 32'd0);
    chk("async_rst_met_valid", {30'd0, met_valid}, 32'd0);
    chk("async_rst_code_met", {30'd0, code_met}, 32'd0);
    cond_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    drv(5'b00000, 5'b00000, 0, 0, CC_NE, CC_EQ, 2'b11, 1, 0);

    // Fill to full, overflow, then unwind in reverse order
    drv(5'b11111, 5'b00011, 0, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    drv(5'b11111, 5'b10100, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    drv(5'b11111, 5'b01001, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    drv(5'b11111, 5'b11011, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    chk("cnt3b_full", {31'd0, stack_full}, 32'd0);
    drv(5'b11111, 5'b00000, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    chk("full_flag", {31'd0, stack_full}, 32'd1);
    chk("full_no_err", {31'd0, stack_err}, 32'd0);
    drv(5'b00000, 5'b00000, 1, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    chk("overflow_err", {31'd0, stack_err}, 32'd1);
    chk("overflow_full", {31'd0, stack_full}, 32'd1);
    drv(5'b11111, 5'b00000, 0, 1, CC_LT, CC_UC, 2'b01, 0, 0);
    chk("unwind1_flags", {27'd0, flags}, 32'h1B);
    chk("unwind1_full", {31'd0, stack_full}, 32'd0);
    drv(5'b00000, 5'b00000, 0, 1, CC_UC, CC_LT, 2'b10, 0, 1);
    chk("unwind2_flags", {27'd0, flags}, 32'h09);
    drv(5'b00000, 5'b00000, 0, 1, CC_UC, CC_UC, 2'b00, 0, 0);
    chk("unwind3_flags", {27'd0, flags}, 32'h14);
    drv(5'b00000, 5'b00000, 0, 1, CC_EQ, CC_UC, 2'b01, 1, 0);
    chk("unwind4_flags", {27'd0, flags}, 32'h03);
    chk("unwind4_empty", {31'd0, stack_empty}, 32'd1);
    chk("sticky_err", {31'd0, stack_err}, 32'd1);

    drv(5'b00000, 5'b00000, 0, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    drv(5'b00000, 5'b00000, 0, 0, CC_UC, CC_UC, 2'b00, 0, 0);
    chk("ch0_results_drained", q0.size(), 32'd0);
    chk("ch1_results_drained", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flag_cond_unit.md
FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent condition-evaluation channels (1..8).
REQ-002 Parameter STACK_DEPTH, default 4, number of flag-save entries for interrupt entry/exit (power of 2, 2..16).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flag_we  input  5  per-flag write enable, bit order {C,L,F,N,Z} (bit 4 = C, bit 0 = Z).
REQ-006 flag_in  input  5  new flag values from the ALU, same bit order.
REQ-007 push  input  1  save current flags onto the flag stack.
REQ-008 pop  input  1  restore flags from the top of the flag stack.
REQ-009 cond_code  input  4*NUM_CH  per-channel 4-bit condition code; channel i occupies bits [4i+3:4i].
REQ-010 cond_valid  input  NUM_CH  per-channel request strobe.
REQ-011 code_met  output  NUM_CH  registered per-channel condition result.
REQ-012 met_valid  output  NUM_CH  registered per-channel result-valid strobe.
REQ-013 flags  output  5  current architectural flags {C,L,F,N,Z}.
REQ-014 stack_full / stack_empty  output  1 each  flag-stack occupancy status.
REQ-015 stack_err  output  1  sticky overflow/underflow indicator.

Function
REQ-016 Flag register: each bit loads flag_in[b] when flag_we[b]=1, otherwise holds.
REQ-017 Predicates (encodings from shared defines): EQ Z; NE !Z; GE N|Z; CS C; CC !C; HI L; LS !L; LO !(L&Z); HS !(L|Z); GRT N; LE !N; FS F; FC !F; LT !(N&Z); UC 0; AT 1; any unlisted code 0.
REQ-018 Evaluation uses forwarded next-flags: the value the flag register will hold after this edge, including flag_we updates and pop restore.
REQ-019 Latency 1: met_valid[i] <= cond_valid[i]; code_met[i] <= predicate(cond_code[i], next-flags) when cond_valid[i]=1, else 0.
REQ-020 Channels are fully independent; any subset may be valid in a cycle.
REQ-021 Stack: LIFO of 5-bit entries with a pointer/count 0..STACK_DEPTH; stack_empty = (count==0), stack_full = (count==STACK_DEPTH), both combinational from count.
REQ-022 Push (push=1, pop=0, not full): writes pre-update flags to the stack, count+1; a same-cycle flag_we update still applies to the flag register.
REQ-023 Pop (pop=1, push=0, not empty): flag register <= top entry, count-1; pop overrides flag_we for all five bits in that cycle.
REQ-024 Push when full or pop when empty: stack and count unchanged, stack_err <= 1; flag_we still applies on an ignored pop.
REQ-025 push and pop in the same cycle: stack no-op, no error, flag_we applies normally.
REQ-026 stack_err is cleared only by reset.

Reset
REQ-027 On reset assertion, immediately: flags=0, count=0 (stack_empty=1, stack_full=0), stack_err=0, code_met=0, met_valid=0; stack contents need not be cleared.
REQ-028 Requests in flight when reset asserts are discarded; the first result after deassertion corresponds to a request in the first post-reset cycle.

Structure
REQ-029 Condition-code encodings and flag bit indices (C=4, L=3, F=2, N=1, Z=0) live in the shared defines file; no local redefinition.
REQ-030 Predicate logic is a combinational sub-module flag_cond_eval (4-bit code + 5 flags -> 1 bit), instantiated NUM_CH times via generate.

Verification
REQ-031 flag_we=5'b00001, flag_in Z=1, cond_valid[0]=1, code EQ in the same cycle -> next cycle code_met[0]=1, met_valid[0]=1 (forwarding), flags=5'b00001.
REQ-032 Flags C=1, L=0; ch0=CS, ch1=HI, both valid -> next cycle code_met=2'b01; ch1 cond_valid=0 -> met_valid[1]=0, code_met[1]=0.
REQ-033 Push 4 distinct flag values (default depth) -> stack_full=1; 5th push -> stack_err=1, count unchanged; 4 pops restore the values in reverse order -> stack_empty=1.
REQ-034 Pop on empty with flag_we=5'b10000, flag_in C=1 -> stack_err=1, flags C=1; push+pop in the same cycle at count=2 -> count stays 2, no error.
REQ-035 Pop with flag_we=5'b11111 in the same cycle -> flags equal the popped entry; a same-cycle LT request is evaluated on the popped flags.
REQ-036 Reset asserted mid-cycle with count=3, stack_err=1 -> immediately flags=0, stack_empty=1, stack_err=0, met_valid=0.
